// File: rtl/word_demux_if.sv
// Handshake bundle for word_demux: one source stream and two destination slots.
// Word buses use ascending [0:WIDTH-1] ranges, so bit 0 is the MSB.
interface word_demux_if #(
    parameter int WIDTH = 16
);
    logic [0:WIDTH-1] i_val;
    logic             i_sel;
    logic             i_valid;
    logic             o_ready;
    logic [0:WIDTH-1] o_val0;
    logic [0:WIDTH-1] o_val1;
    logic             o_valid0;
    logic             o_valid1;
    logic             i_ready0;
    logic             i_ready1;

    modport slave (
        input  i_val, i_sel, i_valid, i_ready0, i_ready1,
        output o_ready, o_val0, o_val1, o_valid0, o_valid1
    );

    modport master (
        output i_val, i_sel, i_valid, i_ready0, i_ready1,
        input  o_ready, o_val0, o_val1, o_valid0, o_valid1
    );
endinterface

// File: rtl/word_demux.sv
// Routes a source word into one of two single-entry destination slots chosen by i_sel.
// Define WORD_DEMUX_COUNT_EN to add 8-bit per-port pop counters (o_cnt0/o_cnt1).
module word_demux #(
    parameter int WIDTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    word_demux_if.slave   bus
`ifdef WORD_DEMUX_COUNT_EN
    ,
    output logic [7:0]    o_cnt0,
    output logic [7:0]    o_cnt1
`endif
);
    localparam logic [0:WIDTH-1] ZERO_WORD = '0;

    logic [0:WIDTH-1] word0;
    logic [0:WIDTH-1] word1;
    logic             full0;
    logic             full1;
    logic             room0;
    logic             room1;
    logic             sel_room;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;

    // A slot has room if it is empty or being drained in the same cycle.
    assign room0    = !full0 || bus.i_ready0;
    assign room1    = !full1 || bus.i_ready1;
    assign sel_room = bus.i_sel ? room1 : room0;

    assign push0 = bus.i_valid && sel_room && !bus.i_sel;
    assign push1 = bus.i_valid && sel_room &&  bus.i_sel;
    assign pop0  = full0 && bus.i_ready0;
    assign pop1  = full1 && bus.i_ready1;

    assign bus.o_ready  = sel_room;
    assign bus.o_val0   = word0;
    assign bus.o_val1   = word1;
    assign bus.o_valid0 = full0;
    assign bus.o_valid1 = full1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word0 <= ZERO_WORD;
            word1 <= ZERO_WORD;
            full0 <= 1'b0;
            full1 <= 1'b0;
        end else begin
            if (push0) begin
                word0 <= bus.i_val;
            end
            if (push1) begin
                word1 <= bus.i_val;
            end
            full0 <= push0 || (full0 && !pop0);
            full1 <= push1 || (full1 && !pop1);
        end
    end

`ifdef WORD_DEMUX_COUNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cnt0 <= 8'd0;
            o_cnt1 <= 8'd0;
        end else begin
            if (pop0) begin
                o_cnt0 <= o_cnt0 + 8'd1;
            end
            if (pop1) begin
                o_cnt1 <= o_cnt1 + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_word_demux.sv
// Directed self-checking bench for word_demux; counter checks run when WORD_DEMUX_COUNT_EN is defined.
module tb_word_demux;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
`ifdef WORD_DEMUX_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    word_demux_if #(.WIDTH(16)) bus ();

    word_demux #(.WIDTH(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef WORD_DEMUX_COUNT_EN
        ,
        .o_cnt0 (cnt0),
        .o_cnt1 (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_valid  = 1'b0;
        bus.i_sel    = 1'b0;
        bus.i_val    = 16'h0000;
        bus.i_ready0 = 1'b0;
        bus.i_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if (bus.o_valid0 !== 1'b0 || bus.o_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b%b exp 00", bus.o_valid0, bus.o_valid1);
        end
        checks++;
        if (bus.o_val0 !== 16'h0000 || bus.o_val1 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_val got %h %h exp 0000 0000", bus.o_val0, bus.o_val1);
        end
        // accepted during reset, then discarded
        bus.i_valid = 1'b1;
        bus.i_val   = 16'h1234;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", bus.o_ready);
        end
        step();
        checks++;
        if (bus.o_valid0 !== 1'b0 || bus.o_val0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_discard got %b %h exp 0 0000", bus.o_valid0, bus.o_val0);
        end
`ifdef WORD_DEMUX_COUNT_EN
        checks++;
        if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d %0d exp 0 0", cnt0, cnt1);
        end
`endif
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_no_valid();
        bus.i_valid = 1'b0;
        bus.i_sel   = 1'b1;
        bus.i_val   = 16'hFFFF;
        step();
        checks++;
        if (bus.o_valid0 !== 1'b0 || bus.o_valid1 !== 1'b0 || bus.o_val1 !== 16'h0000) begin
            errors++;
            $display("FAIL no_valid got %b%b %h exp 00 0000", bus.o_valid0, bus.o_valid1, bus.o_val1);
        end
        idle_inputs();
    endtask

    task automatic test_basic();
        bus.i_valid  = 1'b1;
        bus.i_sel    = 1'b0;
        bus.i_val    = 16'h0115;
        bus.i_ready0 = 1'b1;
        step();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_val0 !== 16'h0115 || bus.o_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL basic_port0 got %h %b exp 0115 1", bus.o_val0, bus.o_valid0);
        end
        checks++;
        if (bus.o_valid1 !== 1'b0 || bus.o_val1 !== 16'h0000) begin
            errors++;
            $display("FAIL basic_port1 got %b %h exp 0 0000", bus.o_valid1, bus.o_val1);
        end
        step();
        checks++;
        if (bus.o_valid0 !== 1'b0 || bus.o_val0 !== 16'h0115) begin
            errors++;
            $display("FAIL basic_pop got %b %h exp 0 0115", bus.o_valid0, bus.o_val0);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bus.i_ready1 = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_sel    = 1'b1;
        bus.i_val    = 16'h0A0A;
        step();
        checks++;
        if (bus.o_valid1 !== 1'b1 || bus.o_val1 !== 16'h0A0A) begin
            errors++;
            $display("FAIL bp_fill got %b %h exp 1 0a0a", bus.o_valid1, bus.o_val1);
        end
        bus.i_val = 16'h00EA;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low got %b exp 0", bus.o_ready);
        end
        bus.i_sel = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_other_ready got %b exp 1", bus.o_ready);
        end
        bus.i_valid = 1'b1;
        bus.i_sel   = 1'b1;
        step();
        checks++;
        if (bus.o_val1 !== 16'h0A0A || bus.o_valid1 !== 1'b1 || bus.o_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got %h %b %b exp 0a0a 1 0", bus.o_val1, bus.o_valid1, bus.o_valid0);
        end
        bus.i_ready1 = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_high got %b exp 1", bus.o_ready);
        end
        step();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_val1 !== 16'h00EA || bus.o_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got %h %b exp 00ea 1", bus.o_val1, bus.o_valid1);
        end
        step();
        checks++;
        if (bus.o_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got %b exp 0", bus.o_valid1);
        end
        idle_inputs();
    endtask

    task automatic test_alternate();
        logic [15:0] words [4];
        logic [0:15] got;
        logic        gv;
        logic        ov;
        words[0] = 16'h01FF;
        words[1] = 16'h0013;
        words[2] = 16'h01FE;
        words[3] = 16'h0012;
        bus.i_ready0 = 1'b1;
        bus.i_ready1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_valid = 1'b1;
            bus.i_sel   = k[0];
            bus.i_val   = words[k];
            #1;
            checks++;
            if (bus.o_ready !== 1'b1) begin
                errors++;
                $display("FAIL alt_ready[%0d] got %b exp 1", k, bus.o_ready);
            end
            step();
            got = k[0] ? bus.o_val1 : bus.o_val0;
            gv  = k[0] ? bus.o_valid1 : bus.o_valid0;
            ov  = k[0] ? bus.o_valid0 : bus.o_valid1;
            checks++;
            if (got !== words[k] || gv !== 1'b1 || ov !== 1'b0) begin
                errors++;
                $display("FAIL alt_word[%0d] got %h %b %b exp %h 1 0", k, got, gv, ov, words[k]);
            end
        end
        bus.i_valid = 1'b0;
        step();
        idle_inputs();
    endtask

    task automatic test_xz();
        logic [0:15] zv;
        logic [0:15] xv;
        zv = 16'hzzzz;
        xv = 16'hxxxx;
        bus.i_valid = 1'b1;
        bus.i_sel   = 1'b1;
        bus.i_val   = zv;
        step();
        checks++;
        if (bus.o_val1 !== zv || bus.o_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL xz_port1 got %h %b exp %h 1", bus.o_val1, bus.o_valid1, zv);
        end
        checks++;
        if (bus.o_val0 !== 16'h01FE || bus.o_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL xz_port0_untouched got %h %b exp 01fe 0", bus.o_val0, bus.o_valid0);
        end
        bus.i_sel = 1'b0;
        bus.i_val = xv;
        step();
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_val0 !== xv || bus.o_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL xz_port0 got %h %b exp %h 1", bus.o_val0, bus.o_valid0, xv);
        end
        checks++;
        if (bus.o_val1 !== zv || bus.o_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL xz_port1_held got %h %b exp %h 1", bus.o_val1, bus.o_valid1, zv);
        end
        bus.i_ready0 = 1'b1;
        bus.i_ready1 = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset_collision();
        bus.i_valid = 1'b1;
        bus.i_sel   = 1'b0;
        bus.i_val   = 16'h0777;
        step();
        checks++;
        if (bus.o_valid0 !== 1'b1 || bus.o_val0 !== 16'h0777) begin
            errors++;
            $display("FAIL coll_fill got %b %h exp 1 0777", bus.o_valid0, bus.o_val0);
        end
        bus.i_ready0 = 1'b1;
        bus.i_val    = 16'h0888;
        rst          = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (bus.o_valid0 !== 1'b0 || bus.o_val0 !== 16'h0000) begin
            errors++;
            $display("FAIL coll_reset got %b %h exp 0 0000", bus.o_valid0, bus.o_val0);
        end
    endtask

`ifdef WORD_DEMUX_COUNT_EN
    task automatic test_counters();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        bus.i_ready0 = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_sel    = 1'b0;
        for (int k = 0; k < 257; k++) begin
            bus.i_val = k[15:0];
            step();
        end
        bus.i_valid = 1'b0;
        step();
        checks++;
        if (cnt0 !== 8'd1 || cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap got %0d %0d exp 1 0", cnt0, cnt1);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_no_valid();
        test_basic();
        test_backpressure();
        test_alternate();
        test_xz();
        test_reset_collision();
`ifdef WORD_DEMUX_COUNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
